// File: rtl/ascon_pkg.sv
// Shared types, round counts and round-constant table for the Ascon permutation.
package ascon_pkg;

    typedef logic [4:0][63:0] ascon_state_t;
    typedef logic [3:0]       rnd_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } ctrl_state_e;

    localparam int ROUNDS_P12 = 12;
    localparam int ROUNDS_P8  = 8;

    // Entry i is the constant XORed into x2 for global round index i.
    localparam logic [11:0][7:0] RC_LUT = {
        8'h4b, 8'h5a, 8'h69, 8'h78, 8'h87, 8'h96,
        8'ha5, 8'hb4, 8'hc3, 8'hd2, 8'he1, 8'hf0
    };

    function automatic rnd_t num_rounds(input logic cfg);
        return cfg ? rnd_t'(ROUNDS_P12) : rnd_t'(ROUNDS_P8);
    endfunction

    function automatic logic [63:0] ror64(input logic [63:0] x, input int unsigned n);
        return (x >> n) | (x << (64 - n));
    endfunction

endpackage

// File: rtl/ascon_round.sv
// One combinational Ascon round: constant addition, 5-bit S-box layer, linear diffusion.
module ascon_round
    import ascon_pkg::*;
(
    input  rnd_t         rnd_i,
    input  logic         round_config_i,
    input  ascon_state_t state_array_i,
    output ascon_state_t state_array_o
);

    rnd_t         idx;
    ascon_state_t s;
    ascon_state_t t;

    always_comb begin
        // p[8] uses the last eight constants of the p[12] schedule.
        idx = round_config_i ? rnd_i : rnd_t'(rnd_i + 4'd4);
        s = state_array_i;
        s[2][7:0] = s[2][7:0] ^ RC_LUT[idx];

        s[0] = s[0] ^ s[4];
        s[4] = s[4] ^ s[3];
        s[2] = s[2] ^ s[1];
        for (int i = 0; i < 5; i++) begin
            t[i] = ~s[i] & s[(i + 1) % 5];
        end
        for (int i = 0; i < 5; i++) begin
            s[i] = s[i] ^ t[(i + 1) % 5];
        end
        s[1] = s[1] ^ s[0];
        s[0] = s[0] ^ s[4];
        s[3] = s[3] ^ s[2];
        s[2] = ~s[2];

        state_array_o[0] = s[0] ^ ror64(s[0], 19) ^ ror64(s[0], 28);
        state_array_o[1] = s[1] ^ ror64(s[1], 61) ^ ror64(s[1], 39);
        state_array_o[2] = s[2] ^ ror64(s[2], 1)  ^ ror64(s[2], 6);
        state_array_o[3] = s[3] ^ ror64(s[3], 10) ^ ror64(s[3], 17);
        state_array_o[4] = s[4] ^ ror64(s[4], 7)  ^ ror64(s[4], 41);
    end

endmodule

// File: rtl/ascon_permutation_ctrl.sv
// Iterative Ascon p[12]/p[8] engine with valid/ready handshakes on both sides.
// Define ASCON_DUAL_ROUND_EN to unroll two rounds per clock.
module ascon_permutation_ctrl
    import ascon_pkg::*;
#(
    parameter bit CLEAR_ON_RST = 1'b1
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic         round_config_i,
    input  ascon_state_t state_array_i,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output ascon_state_t state_array_o,
    output rnd_t         rnd_o
);

`ifdef ASCON_DUAL_ROUND_EN
    localparam int RPC = 2;
`else
    localparam int RPC = 1;
`endif
    localparam rnd_t STEP = rnd_t'(RPC);

    ctrl_state_e  st_q, st_d;
    ascon_state_t state_q;
    rnd_t         cnt_q;
    logic         cfg_q;
    logic         last_step;
    logic         accept;
    ascon_state_t chain [RPC+1];

    assign chain[0] = state_q;

    for (genvar g = 0; g < RPC; g++) begin : g_round
        rnd_t rnd_g;
        assign rnd_g = cnt_q + rnd_t'(g);
        ascon_round u_round (
            .rnd_i          (rnd_g),
            .round_config_i (cfg_q),
            .state_array_i  (chain[g]),
            .state_array_o  (chain[g+1])
        );
    end

    // Final step is the one whose last round lands on the schedule's end.
    assign last_step = (rnd_t'(cnt_q + STEP) == num_rounds(cfg_q));
    assign accept    = in_ready_o & in_valid_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) st_q <= ST_IDLE;
        else       st_q <= st_d;
    end

    always_comb begin
        st_d = st_q;
        case (st_q)
            ST_IDLE: if (in_valid_i)  st_d = ST_RUN;
            ST_RUN:  if (last_step)   st_d = ST_DONE;
            ST_DONE: if (out_ready_i) st_d = ST_IDLE;
            default:                  st_d = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready_o  = 1'b0;
        out_valid_o = 1'b0;
        case (st_q)
            ST_IDLE: in_ready_o  = 1'b1;
            ST_DONE: out_valid_o = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
            cfg_q <= 1'b0;
            if (CLEAR_ON_RST) state_q <= '0;
        end else if (accept) begin
            state_q <= state_array_i;
            cfg_q   <= round_config_i;
            cnt_q   <= '0;
        end else if (st_q == ST_RUN) begin
            state_q <= chain[RPC];
            if (!last_step) cnt_q <= cnt_q + STEP;
        end
    end

    assign state_array_o = state_q;
    assign rnd_o         = cnt_q;

endmodule
